collision_scanner: RTL and testbench

//  Multi-cycle collision/food checker that replaces the single-cycle combinational detector.

---
 rtl/collision_scanner_if.sv | 40 ++++
 rtl/collision_scanner.sv | 206 ++++++++++++++++++++
 tb/tb_collision_scanner.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/collision_scanner_if.sv
// Handshake and result bundle between the game FSM (master) and collision_scanner (slave).
// The wrap_mode signal exists only when WALL_WRAP_EN is defined.
interface collision_scanner_if #(
  parameter int MAX_LEN  = 64,
  parameter int POS_BITS = 13,
  parameter int FOOD_CNT = 2
);
  logic                          start;
  logic [POS_BITS-1:0]           snake_head;
  logic [MAX_LEN*POS_BITS-1:0]   snake_body_flat;
  logic [$clog2(MAX_LEN+1)-1:0]  snake_length;
  logic [1:0]                    direction_in;
  logic [FOOD_CNT*POS_BITS-1:0]  food_flat;
`ifdef WALL_WRAP_EN
  logic                          wrap_mode;
`endif
  logic                          busy;
  logic                          done;
  logic                          collision;
  logic                          wall_hit;
  logic                          self_hit;
  logic [$clog2(MAX_LEN)-1:0]    hit_index;
  logic [FOOD_CNT-1:0]           food_hit;

  modport master (
`ifdef WALL_WRAP_EN
    output wrap_mode,
`endif
    output start, snake_head, snake_body_flat, snake_length, direction_in, food_flat,
    input  busy, done, collision, wall_hit, self_hit, hit_index, food_hit
  );

  modport slave (
`ifdef WALL_WRAP_EN
    input  wrap_mode,
`endif
    input  start, snake_head, snake_body_flat, snake_length, direction_in, food_flat,
    output busy, done, collision, wall_hit, self_hit, hit_index, food_hit
  );
endinterface

// File: rtl/collision_scanner.sv
// Multi-cycle head-vs-body/food/wall checker scanning LANES body segments per cycle.
// Define WALL_WRAP_EN to add wrap_mode, which suppresses wall kills and forces the self scan.
module collision_scanner #(
  parameter int MAX_LEN  = 64,
  parameter int POS_BITS = 13,
  parameter int GRID_W   = 100,
  parameter int GRID_H   = 75,
  parameter int LANES    = 4,
  parameter int FOOD_CNT = 2
) (
  input logic                clk,
  input logic                rst,
  collision_scanner_if.slave bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = LW + 1;
  localparam int HW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r, state_next_s;
  logic [POS_BITS-1:0] head_r, head_next_s;
  logic [IW-1:0]       len_r, len_next_s;
  logic [IW-1:0]       idx_r, idx_next_s;
  logic                busy_r, busy_next_s;
  logic                done_r, done_next_s;
  logic                wall_r, wall_next_s;
  logic                self_r, self_next_s;
  logic                collision_r, collision_next_s;
  logic [HW-1:0]       hit_index_r, hit_index_next_s;
  logic [FOOD_CNT-1:0] food_r, food_next_s;

  logic                wall_s;
  logic [FOOD_CNT-1:0] food_s;
  logic [IW-1:0]       start_len_s;
  logic                lane_hit_s;
  logic [IW-1:0]       lane_idx_s;
  logic [IW-1:0]       cand_s;
  logic                match_s;

  function automatic logic [POS_BITS-1:0] seg_at(
    input logic [MAX_LEN*POS_BITS-1:0] flat,
    input logic [IW-1:0]               i
  );
    if (i < IW'(MAX_LEN)) begin
      seg_at = flat[32'(i)*POS_BITS +: POS_BITS];
    end else begin
      seg_at = '0;
    end
  endfunction

  function automatic logic wall_check(input logic [POS_BITS-1:0] pos, input logic [1:0] dir);
    int unsigned x;
    int unsigned y;
    x = 32'(pos) % GRID_W;
    y = 32'(pos) / GRID_W;
    case (dir)
      2'b00:   wall_check = (y == 32'd0);
      2'b01:   wall_check = (x == 32'(GRID_W - 1));
      2'b10:   wall_check = (y == 32'(GRID_H - 1));
      2'b11:   wall_check = (x == 32'd0);
      default: wall_check = 1'b0;
    endcase
  endfunction

  // len=0 behaves as a lone head; oversized lengths saturate at MAX_LEN
  function automatic logic [IW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == '0) begin
      clamp_len = IW'(1);
    end else if (l > LW'(MAX_LEN)) begin
      clamp_len = IW'(MAX_LEN);
    end else begin
      clamp_len = IW'(l);
    end
  endfunction

`ifdef WALL_WRAP_EN
  assign wall_s = bus.wrap_mode ? 1'b0 : wall_check(bus.snake_head, bus.direction_in);
`else
  assign wall_s = wall_check(bus.snake_head, bus.direction_in);
`endif
  assign start_len_s = clamp_len(bus.snake_length);

  // Food slot comparators on the incoming head
  always_comb begin
    food_s = '0;
    for (int k = 0; k < FOOD_CNT; k++) begin
      food_s[k] = (bus.snake_head == bus.food_flat[k*POS_BITS +: POS_BITS]);
    end
  end

  // Body lane comparators; walking downward lets the lowest matching index win
  always_comb begin
    lane_hit_s = 1'b0;
    lane_idx_s = '0;
    cand_s     = '0;
    match_s    = 1'b0;
    for (int l = LANES - 1; l >= 0; l--) begin
      cand_s     = idx_r + IW'(l);
      match_s    = (cand_s < len_r) && (seg_at(bus.snake_body_flat, cand_s) == head_r);
      lane_idx_s = match_s ? cand_s : lane_idx_s;
      lane_hit_s = lane_hit_s | match_s;
    end
  end

  // Next-state and next-output logic of the scan FSM
  always_comb begin
    state_next_s     = state_r;
    head_next_s      = head_r;
    len_next_s       = len_r;
    idx_next_s       = idx_r;
    busy_next_s      = busy_r;
    done_next_s      = 1'b0;
    wall_next_s      = wall_r;
    self_next_s      = self_r;
    collision_next_s = collision_r;
    hit_index_next_s = hit_index_r;
    food_next_s      = food_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          head_next_s      = bus.snake_head;
          len_next_s       = start_len_s;
          idx_next_s       = IW'(1);
          busy_next_s      = 1'b1;
          wall_next_s      = wall_s;
          food_next_s      = food_s;
          self_next_s      = 1'b0;
          hit_index_next_s = '0;
          collision_next_s = wall_s;
          if (wall_s || (start_len_s <= IW'(1))) begin
            state_next_s = DONE;
            done_next_s  = 1'b1;
          end else begin
            state_next_s = SCAN;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (lane_hit_s) begin
          self_next_s      = 1'b1;
          collision_next_s = 1'b1;
          hit_index_next_s = HW'(lane_idx_s);
          state_next_s     = DONE;
          done_next_s      = 1'b1;
        end else if ((idx_r + IW'(LANES)) >= len_r) begin
          state_next_s = DONE;
          done_next_s  = 1'b1;
        end else begin
          idx_next_s = idx_r + IW'(LANES);
        end
      end
      DONE: begin
        state_next_s = IDLE;
        busy_next_s  = 1'b0;
      end
      default: begin
        state_next_s = IDLE;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      head_r      <= '0;
      len_r       <= '0;
      idx_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wall_r      <= 1'b0;
      self_r      <= 1'b0;
      collision_r <= 1'b0;
      hit_index_r <= '0;
      food_r      <= '0;
    end else begin
      state_r     <= state_next_s;
      head_r      <= head_next_s;
      len_r       <= len_next_s;
      idx_r       <= idx_next_s;
      busy_r      <= busy_next_s;
      done_r      <= done_next_s;
      wall_r      <= wall_next_s;
      self_r      <= self_next_s;
      collision_r <= collision_next_s;
      hit_index_r <= hit_index_next_s;
      food_r      <= food_next_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.wall_hit  = wall_r;
  assign bus.self_hit  = self_r;
  assign bus.collision = collision_r;
  assign bus.hit_index = hit_index_r;
  assign bus.food_hit  = food_r;
endmodule

// File: tb/tb_collision_scanner.sv
// Table-driven bench for collision_scanner with a scoreboard queue of expected results.
module tb_collision_scanner;
  localparam int MAX_LEN  = 64;
  localparam int POS_BITS = 13;
  localparam int FOOD_CNT = 2;

  typedef struct {
    logic [12:0] head;
    logic [6:0]  len;
    logic [1:0]  dir;
    logic [12:0] b1, b2, b3;
    int          mpos;
    logic [12:0] mval;
    logic [12:0] f0, f1;
    logic        wrap;
    logic        ewall;
    logic        eself;
    int          eidx;
    logic [1:0]  efood;
    int          elat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  vec_t sb[$];

  collision_scanner_if #(.MAX_LEN(MAX_LEN), .POS_BITS(POS_BITS), .FOOD_CNT(FOOD_CNT)) bus ();

  collision_scanner #(
    .MAX_LEN(MAX_LEN), .POS_BITS(POS_BITS), .GRID_W(100), .GRID_H(75), .LANES(4), .FOOD_CNT(FOOD_CNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [12:0] head, input logic [6:0] len, input logic [1:0] dir,
    input logic [12:0] b1, input logic [12:0] b2, input logic [12:0] b3,
    input int mpos, input logic [12:0] mval, input logic [12:0] f0, input logic [12:0] f1,
    input logic wrap, input logic ewall, input logic eself, input int eidx,
    input logic [1:0] efood, input int elat
  );
    vec_t v;
    v.head = head; v.len = len; v.dir = dir; v.b1 = b1; v.b2 = b2; v.b3 = b3;
    v.mpos = mpos; v.mval = mval; v.f0 = f0; v.f1 = f1; v.wrap = wrap;
    v.ewall = ewall; v.eself = eself; v.eidx = eidx; v.efood = efood; v.elat = elat;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    logic [12:0] body [MAX_LEN];
    for (int i = 0; i < MAX_LEN; i++) body[i] = 13'(7000 + i);
    body[1] = v.b1;
    body[2] = v.b2;
    body[3] = v.b3;
    if (v.mpos != 0) body[v.mpos] = v.mval;
    for (int i = 0; i < MAX_LEN; i++) bus.snake_body_flat[i*POS_BITS +: POS_BITS] = body[i];
    bus.snake_head   = v.head;
    bus.snake_length = v.len;
    bus.direction_in = v.dir;
    bus.food_flat    = {v.f1, v.f0};
`ifdef WALL_WRAP_EN
    bus.wrap_mode    = v.wrap;
`endif
  endtask

  // inject > 0: pulse a lethal-looking start on that cycle of the scan; it must be ignored
  task automatic run_vec(input vec_t v, input string name, input int inject);
    int   n;
    bit   seen;
    vec_t e;
    @(negedge clk);
    drive_vec(v);
    bus.start = 1'b1;
    @(posedge clk);
    sb.push_back(v);
    #1 bus.start = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        seen = 1'b1;
      end else if (n == inject) begin
        bus.start = 1'b1;
        bus.snake_head = 13'd10;
        bus.direction_in = 2'b00;
        bus.snake_length = 7'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      check({name, "_timeout"}, 0, 1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check({name, "_latency"}, n, e.elat);
      check({name, "_wall"}, int'(bus.wall_hit), int'(e.ewall));
      check({name, "_self"}, int'(bus.self_hit), int'(e.eself));
      check({name, "_collision"}, int'(bus.collision), int'(e.ewall | e.eself));
      check({name, "_hit_index"}, int'(bus.hit_index), e.eidx);
      check({name, "_food"}, int'(bus.food_hit), int'(e.efood));
      check({name, "_busy_at_done"}, int'(bus.busy), 1);
      @(negedge clk);
      check({name, "_done_pulse"}, int'({bus.done, bus.busy}), 0);
      check({name, "_hold"}, int'(bus.collision), int'(e.ewall | e.eself));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.snake_head = '0;
    bus.snake_body_flat = '0;
    bus.snake_length = '0;
    bus.direction_in = '0;
    bus.food_flat = '0;
`ifdef WALL_WRAP_EN
    bus.wrap_mode = 1'b0;
`endif
    // head, len, dir, b1, b2, b3, mpos, mval, f0, f1, wrap, ewall, eself, eidx, efood, elat
    vecs.push_back(mk(13'd10,   7'd1,   2'b00, 13'd1009, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b1, 1'b0, 0,  2'b00, 1));
    vecs.push_back(mk(13'd1010, 7'd4,   2'b01, 13'd1009, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b0, 1'b0, 0,  2'b00, 2));
    vecs.push_back(mk(13'd1009, 7'd4,   2'b11, 13'd1009, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b0, 1'b1, 1,  2'b00, 2));
    vecs.push_back(mk(13'd3000, 7'd64,  2'b00, 13'd1009, 13'd1008, 13'd1007, 61, 13'd3000, 13'd7400, 13'd7401, 1'b0, 1'b0, 1'b1, 61, 2'b00, 17));
    vecs.push_back(mk(13'd3000, 7'd64,  2'b00, 13'd1009, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b0, 1'b0, 0,  2'b00, 17));
    vecs.push_back(mk(13'd123,  7'd4,   2'b00, 13'd1009, 13'd1008, 13'd1007, 0,  13'd0,    13'd50,   13'd123,  1'b0, 1'b0, 1'b0, 0,  2'b10, 2));
    vecs.push_back(mk(13'd2000, 7'd4,   2'b00, 13'd1009, 13'd1008, 13'd1007, 4,  13'd2000, 13'd7400, 13'd7401, 1'b0, 1'b0, 1'b0, 0,  2'b00, 2));
    vecs.push_back(mk(13'd2000, 7'd5,   2'b00, 13'd1009, 13'd1008, 13'd1007, 4,  13'd2000, 13'd7400, 13'd7401, 1'b0, 1'b0, 1'b1, 4,  2'b00, 2));
    vecs.push_back(mk(13'd2000, 7'd6,   2'b00, 13'd1009, 13'd1008, 13'd1007, 5,  13'd2000, 13'd7400, 13'd7401, 1'b0, 1'b0, 1'b1, 5,  2'b00, 3));
    vecs.push_back(mk(13'd2000, 7'd0,   2'b00, 13'd2000, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b0, 1'b0, 0,  2'b00, 1));
    vecs.push_back(mk(13'd5099, 7'd4,   2'b01, 13'd5099, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b1, 1'b0, 0,  2'b00, 1));
    vecs.push_back(mk(13'd7450, 7'd4,   2'b10, 13'd1009, 13'd1008, 13'd1007, 0,  13'd0,    13'd7450, 13'd50,   1'b0, 1'b1, 1'b0, 0,  2'b01, 1));
    vecs.push_back(mk(13'd3000, 7'd4,   2'b11, 13'd1009, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b1, 1'b0, 0,  2'b00, 1));
    vecs.push_back(mk(13'd0,    7'd1,   2'b01, 13'd1009, 13'd1008, 13'd1007, 0,  13'd0,    13'd0,    13'd0,    1'b0, 1'b0, 1'b0, 0,  2'b11, 1));
    vecs.push_back(mk(13'd2000, 7'd8,   2'b00, 13'd1009, 13'd2000, 13'd2000, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b0, 1'b1, 2,  2'b00, 2));
    vecs.push_back(mk(13'd2000, 7'd2,   2'b00, 13'd2000, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b0, 1'b1, 1,  2'b00, 2));
    vecs.push_back(mk(13'd2000, 7'd2,   2'b00, 13'd1009, 13'd2000, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b0, 1'b0, 0,  2'b00, 2));
    vecs.push_back(mk(13'd3000, 7'd100, 2'b00, 13'd1009, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b0, 1'b0, 1'b0, 0,  2'b00, 17));
`ifdef WALL_WRAP_EN
    vecs.push_back(mk(13'd5099, 7'd1,   2'b01, 13'd1009, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b1, 1'b0, 1'b0, 0,  2'b00, 1));
    vecs.push_back(mk(13'd5099, 7'd4,   2'b01, 13'd5099, 13'd1008, 13'd1007, 0,  13'd0,    13'd7400, 13'd7401, 1'b1, 1'b0, 1'b1, 1,  2'b00, 2));
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({bus.busy, bus.done, bus.collision, bus.wall_hit,
                                 bus.self_hit, bus.hit_index, bus.food_hit}), 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 0);
    end

    // Start pulsed mid-scan must be ignored and leave no queued transaction
    run_vec(vecs[4], "busy_start", 4);
    repeat (3) begin
      @(negedge clk);
      check("busy_start_no_requeue", int'({bus.busy, bus.done}), 0);
    end

    // Reset mid-scan: outputs clear on the next edge and no done pulse follows
    begin
      vec_t r;
      bit   saw_done;
      r = mk(13'd3000, 7'd64, 2'b00, 13'd1009, 13'd1008, 13'd1007, 0, 13'd0,
             13'd3000, 13'd7401, 1'b0, 1'b0, 1'b0, 0, 2'b01, 17);
      @(negedge clk);
      drive_vec(r);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_busy", int'(bus.busy), 1);
      check("pre_rst_food", int'(bus.food_hit), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_scan_outputs", int'({bus.busy, bus.done, bus.collision, bus.wall_hit,
                                          bus.self_hit, bus.hit_index, bus.food_hit}), 0);
      saw_done = 1'b0;
      repeat (25) begin
        @(negedge clk);
        saw_done = saw_done | bus.done;
      end
      check("rst_no_done", int'(saw_done), 0);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
